// File: rtl/hazard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard: producer Tnew values,
// consumer Tuse values and default mult/div busy latencies.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W  = 5;

  // Cycles after entering E until the result can be forwarded
  localparam int unsigned TNEW_PC     = 0;
  localparam int unsigned TNEW_ALU    = 1;
  localparam int unsigned TNEW_DM     = 2;

  // Cycles until a decode-stage source is actually consumed
  localparam int unsigned TUSE_0      = 0;
  localparam int unsigned TUSE_1      = 1;
  localparam int unsigned TUSE_2      = 2;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// HI/LO unit busy counter: loads the mult or div latency on start and counts
// down to zero; busy_o is registered and high while the count is non-zero.
module md_busy_ctr
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  localparam int unsigned CNT_W = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = div_i ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage Tnew/Tuse hazard scoreboard with per-GPR countdowns.
// Define HAZARD_MD_EN to add the HI/LO busy interlock (md_busy_ctr).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned TNEW_W  = 2,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_D,
  input  logic [REG_ADDR_W-1:0] rt_D,
  input  logic                  use_rs_D,
  input  logic                  use_rt_D,
  input  logic [TNEW_W-1:0]     tuse_rs_D,
  input  logic [TNEW_W-1:0]     tuse_rt_D,
  input  logic                  wr_en_D,
  input  logic [REG_ADDR_W-1:0] a3_D,
  input  logic [TNEW_W-1:0]     tnew_D,
  input  logic                  md_start_D,
  input  logic                  md_div_D,
  input  logic                  md_use_D,
  output logic                  stall,
  output logic                  md_busy,
  output logic [NREG-1:0]       pend_vec
);

  logic [TNEW_W-1:0] cnt_q [NREG];
  logic [TNEW_W-1:0] cnt_d [NREG];
  logic [TNEW_W-1:0] rs_cnt_c, rt_cnt_c;
  logic              reg_stall_c, md_stall_c, issue_c;

  // Source countdown lookup; register numbers beyond NREG are never pending
  always_comb begin
    rs_cnt_c = '0;
    rt_cnt_c = '0;
    if (32'(rs_D) < NREG) rs_cnt_c = cnt_q[rs_D];
    if (32'(rt_D) < NREG) rt_cnt_c = cnt_q[rt_D];
  end

  assign reg_stall_c = (use_rs_D && (rs_cnt_c > tuse_rs_D)) ||
                       (use_rt_D && (rt_cnt_c > tuse_rt_D));
  assign stall       = reg_stall_c || md_stall_c;
  assign issue_c     = !stall;

  // Saturating decrement everywhere; an issuing write overrides its own slot
  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - TNEW_W'(1)) : '0;
    end
    if (issue_c && wr_en_D && (a3_D != '0) && (32'(a3_D) < NREG)) begin
      cnt_d[a3_D] = tnew_D;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < int'(NREG); r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NREG); r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    pend_vec = '0;
    for (int r = 0; r < int'(NREG); r++) pend_vec[r] = (cnt_q[r] != '0);
  end

`ifdef HAZARD_MD_EN
  md_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_ctr (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (issue_c && md_start_D),
    .div_i   (md_div_D),
    .busy_o  (md_busy)
  );

  assign md_stall_c = (md_start_D || md_use_D) && md_busy;
`else
  localparam int unsigned md_lat_unused = MUL_LAT + DIV_LAT;
  logic md_unused;

  assign md_unused  = ^{md_start_D, md_div_D, md_use_D};
  assign md_busy    = 1'b0;
  assign md_stall_c = 1'b0;
`endif

endmodule
